// File: rtl/text_pixel_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : text_pixel_serializer
//  Description : Text-mode pixel engine. Walks the character cells of the
//                current scanline, fetches each character code from the text
//                buffer and its 10-bit glyph row from the font ROM, and
//                shifts the row out one pixel per pixel tick. The fetch of
//                cell k+1 runs while cell k is being displayed.
//  Revision    : 1.0 - initial release
// ============================================================================
module text_pixel_serializer #(
    parameter int COLS   = 64,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 11
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              PIX_EN,
    input  logic              LINE_START,
    input  logic              FRAME_START,
    input  logic              ACTIVE,
    output logic [ADDR_W-1:0] TEXT_ADDR,
    input  logic [7:0]        TEXT_DATA,
    output logic [7:0]        FONT_CHAR,
    output logic [3:0]        FONT_ROW,
    input  logic [9:0]        FONT_DATA,
    output logic              PIXEL,
    output logic              UNDERRUN
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Fetch column must be able to hold COLS itself ("all cells fetched").
    localparam int c_FCOL_W = $clog2(COLS + 1);
    localparam int c_ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [c_FCOL_W-1:0] c_FCOL_END = c_FCOL_W'(COLS);
    localparam logic [c_ROW_W-1:0]  c_ROW_LAST = c_ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0]   c_COLS_A   = ADDR_W'(COLS);
    localparam logic [3:0]          c_PIX_LAST = 4'd9;
    localparam logic [3:0]          c_SCAN_LAST = 4'd15;

    // Fetch FSM encoding
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_TXT_REQ  = 3'd1;
    localparam logic [2:0] c_ST_FONT_REQ = 3'd2;
    localparam logic [2:0] c_ST_FONT_CAP = 3'd3;
    localparam logic [2:0] c_ST_HOLD     = 3'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [3:0]          r_scan;
    logic [c_ROW_W-1:0]  r_text_row;
    logic                r_first_line;
    logic [c_FCOL_W-1:0] r_fcol;

    logic [ADDR_W-1:0]   r_text_addr;
    logic [7:0]          r_font_char;
    logic [3:0]          r_font_row;
    logic [9:0]          r_next_row;
    logic                r_next_valid;

    logic [9:0]          r_shift;
    logic [3:0]          r_pix_idx;
    logic                r_pixel;
    logic                r_underrun;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [2:0]          w_state_nxt;
    logic [ADDR_W-1:0]   w_row_base;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_tick;
    logic                w_load;
    logic                w_cap;
    logic                w_past_end;

    assign w_row_base = ADDR_W'(r_text_row) * c_COLS_A;
    assign w_addr     = w_row_base + ADDR_W'(r_fcol);

    // A shifter step only happens on a pixel tick inside the active area;
    // a new cell is loaded whenever the pixel index is back at 0.
    assign w_tick     = PIX_EN && ACTIVE;
    assign w_load     = w_tick && (r_pix_idx == 4'd0);
    assign w_cap      = (r_state == c_ST_FONT_CAP);
    // Once every cell of the line has been captured and the last one has been
    // consumed, an empty next_row is expected rather than an underrun.
    assign w_past_end = (r_fcol == c_FCOL_END);

    // ------------------------------------------------------------------------
    // Scanline / text-row bookkeeping, advanced once per line start
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_scan       <= 4'd0;
            r_text_row   <= '0;
            r_first_line <= 1'b1;
        end else if (FRAME_START) begin
            // A line starting in the same cycle is the first line of the
            // frame, so it consumes the first_line marker immediately.
            r_scan       <= 4'd0;
            r_text_row   <= '0;
            r_first_line <= !LINE_START;
        end else if (LINE_START) begin
            if (r_first_line) begin
                r_first_line <= 1'b0;
            end else if (r_scan == c_SCAN_LAST) begin
                r_scan     <= 4'd0;
                r_text_row <= (r_text_row == c_ROW_LAST) ? '0 : r_text_row + c_ROW_W'(1);
            end else begin
                r_scan <= r_scan + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Fetch FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Fetch FSM next-state logic; LINE_START aborts whatever is in flight
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (LINE_START) begin
            w_state_nxt = c_ST_TXT_REQ;
        end else begin
            case (r_state)
                c_ST_IDLE:     w_state_nxt = c_ST_IDLE;
                c_ST_TXT_REQ:  w_state_nxt = c_ST_FONT_REQ;
                c_ST_FONT_REQ: w_state_nxt = c_ST_FONT_CAP;
                c_ST_FONT_CAP: w_state_nxt = c_ST_HOLD;
                c_ST_HOLD: begin
                    // The prefetched row has been taken by the shifter.
                    if (!r_next_valid) begin
                        w_state_nxt = (r_fcol < c_FCOL_END) ? c_ST_TXT_REQ : c_ST_IDLE;
                    end
                end
                default:       w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Fetch datapath: text address, font request and captured glyph row
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_text_addr <= '0;
            r_font_char <= 8'd0;
            r_font_row  <= 4'd0;
            r_next_row  <= 10'd0;
            r_fcol      <= '0;
        end else if (LINE_START) begin
            r_fcol <= '0;
        end else begin
            case (r_state)
                c_ST_TXT_REQ: begin
                    r_text_addr <= w_addr;
                end
                c_ST_FONT_REQ: begin
                    // Text buffer answers one clock after the address.
                    r_font_char <= TEXT_DATA;
                    r_font_row  <= r_scan;
                end
                c_ST_FONT_CAP: begin
                    // Font ROM samples on the falling edge, so its row is
                    // ready one clock after the request.
                    r_next_row <= FONT_DATA;
                    r_fcol     <= r_fcol + c_FCOL_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pixel shifter, prefetch handshake and sticky underrun flag
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_shift      <= 10'd0;
            r_pix_idx    <= 4'd0;
            r_next_valid <= 1'b0;
            r_pixel      <= 1'b0;
            r_underrun   <= 1'b0;
        end else if (LINE_START) begin
            r_shift      <= 10'd0;
            r_pix_idx    <= 4'd0;
            r_next_valid <= 1'b0;
            if (!ACTIVE) begin
                r_pixel <= 1'b0;
            end
        end else begin
            // The FSM only captures while next_valid is low, so this set and
            // the shifter's clear below never target the same cycle.
            if (w_cap) begin
                r_next_valid <= 1'b1;
            end

            if (w_tick) begin
                r_pix_idx <= (r_pix_idx == c_PIX_LAST) ? 4'd0 : r_pix_idx + 4'd1;
                if (w_load) begin
                    if (r_next_valid) begin
                        r_shift      <= r_next_row;
                        r_pixel      <= r_next_row[9];
                        r_next_valid <= 1'b0;
                    end else begin
                        // Nothing ready: show a blank cell. Past the last
                        // cell of the line this is normal, not an error.
                        r_shift <= 10'd0;
                        r_pixel <= 1'b0;
                        if (!w_past_end) begin
                            r_underrun <= 1'b1;
                        end
                    end
                end else begin
                    r_pixel <= r_shift[c_PIX_LAST - r_pix_idx];
                end
            end else if (!ACTIVE) begin
                // Blanking: output dark, but keep the pixel position so the
                // cell resumes where it left off.
                r_pixel <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign TEXT_ADDR = r_text_addr;
    assign FONT_CHAR = r_font_char;
    assign FONT_ROW  = r_font_row;
    assign PIXEL     = r_pixel;
    assign UNDERRUN  = r_underrun;

endmodule
`default_nettype wire
